// File: rtl/cdb_bcast.sv
// cdb_bcast: CDB broadcaster, per-FU completion FIFOs + round-robin one-per-cycle broadcast; flush_i only with CDB_FLUSH_EN
module cdb_bcast #(
  parameter int NUM_FU    = 4,
  parameter int QDEPTH    = 2,
  parameter int PRF_IDX_W = 6,
  parameter int ROB_IDX_W = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_FU-1:0]             fu_done_vld_i,
  input  logic [NUM_FU*PRF_IDX_W-1:0]   fu_done_tag_i,
  input  logic [NUM_FU*ROB_IDX_W-1:0]   fu_done_rob_i,
  output logic [NUM_FU-1:0]             fu_done_rdy_o,
`ifdef CDB_FLUSH_EN
  input  logic                          flush_i,
`endif
  output logic                          cdb_vld_o,
  output logic [PRF_IDX_W-1:0]          cdb_tag_o,
  output logic [ROB_IDX_W-1:0]          cdb_rob_o,
  output logic                          cdb_busy_o
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam int RW = $clog2(NUM_FU);
  localparam int EW = PRF_IDX_W + ROB_IDX_W;
  logic [EW-1:0] mem_q [NUM_FU][QDEPTH];
  logic [EW-1:0] mem_d [NUM_FU][QDEPTH];
  logic [PW-1:0] wp_q [NUM_FU];
  logic [PW-1:0] wp_d [NUM_FU];
  logic [PW-1:0] rp_q [NUM_FU];
  logic [PW-1:0] rp_d [NUM_FU];
  logic [CW-1:0] cnt_q [NUM_FU];
  logic [CW-1:0] cnt_d [NUM_FU];
  logic [RW-1:0] rr_q, rr_d;
  logic vld_q, vld_d;
  logic [PRF_IDX_W-1:0] tag_q, tag_d;
  logic [ROB_IDX_W-1:0] rob_q, rob_d;
  logic [NUM_FU-1:0] push, pop, ne;
  logic win_vld;
  logic [RW-1:0] win;
  logic fl;
`ifdef CDB_FLUSH_EN
  assign fl = flush_i;
`else
  assign fl = 1'b0;
`endif
  always_comb begin
    for (int k = 0; k < NUM_FU; k++) begin
      ne[k] = cnt_q[k] != '0;
      fu_done_rdy_o[k] = cnt_q[k] != CW'(QDEPTH);
      push[k] = fu_done_vld_i[k] & fu_done_rdy_o[k];
      pop[k] = win_vld && win == RW'(k);
    end
  end
  always_comb begin
    win_vld = 1'b0;
    win = '0;
    for (int j = NUM_FU - 1; j >= 0; j--) begin
      if (ne[(int'(rr_q) + j) % NUM_FU]) begin
        win_vld = 1'b1;
        win = RW'((int'(rr_q) + j) % NUM_FU);
      end
    end
  end
  always_comb begin
    mem_d = mem_q;
    wp_d = wp_q;
    rp_d = rp_q;
    cnt_d = cnt_q;
    for (int k = 0; k < NUM_FU; k++) begin
      if (push[k]) begin
        mem_d[k][wp_q[k]] = {fu_done_tag_i[k*PRF_IDX_W +: PRF_IDX_W], fu_done_rob_i[k*ROB_IDX_W +: ROB_IDX_W]};
        wp_d[k] = wp_q[k] + 1'b1;
      end
      rp_d[k] = pop[k] ? rp_q[k] + 1'b1 : rp_q[k];
      cnt_d[k] = cnt_q[k] + CW'(push[k]) - CW'(pop[k]);
      if (fl) begin
        wp_d[k] = '0;
        rp_d[k] = '0;
        cnt_d[k] = '0;
      end
    end
    vld_d = win_vld & ~fl;
    {tag_d, rob_d} = vld_d ? mem_q[win][rp_q[win]] : '0;
    rr_d = fl ? '0 : !win_vld ? rr_q : win == RW'(NUM_FU - 1) ? '0 : win + 1'b1;
  end
  always_ff @(posedge clk) mem_q <= mem_d;
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < NUM_FU; k++) begin
        wp_q[k] <= '0;
        rp_q[k] <= '0;
        cnt_q[k] <= '0;
      end
      rr_q <= '0;
      vld_q <= 1'b0;
      tag_q <= '0;
      rob_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
      rr_q <= rr_d;
      vld_q <= vld_d;
      tag_q <= tag_d;
      rob_q <= rob_d;
    end
  end
  assign cdb_vld_o = vld_q;
  assign cdb_tag_o = tag_q;
  assign cdb_rob_o = rob_q;
  assign cdb_busy_o = |ne;
endmodule

// File: tb/tb_cdb_bcast.sv
// tb_cdb_bcast: directed scoreboard bench for cdb_bcast
module tb_cdb_bcast;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  logic [3:0] vld = '0;
  logic [5:0] tg [4];
  logic [4:0] rb [4];
  logic [3:0] rdy;
  logic cdb_vld_o, cdb_busy_o;
  logic [5:0] cdb_tag_o;
  logic [4:0] cdb_rob_o;
  int checks = 0;
  int errors = 0;
  logic [10:0] e_val [$];
  int e_fu [$];
  logic [5:0] log_tag [$];
  int log_fu [$];
  int n [4];
  logic [3:0] acc;
  always #5 clk = ~clk;
  cdb_bcast dut (
    .clk(clk),
    .rst(rst),
    .fu_done_vld_i(vld),
    .fu_done_tag_i({tg[3], tg[2], tg[1], tg[0]}),
    .fu_done_rob_i({rb[3], rb[2], rb[1], rb[0]}),
    .fu_done_rdy_o(rdy),
`ifdef CDB_FLUSH_EN
    .flush_i(flush),
`endif
    .cdb_vld_o(cdb_vld_o),
    .cdb_tag_o(cdb_tag_o),
    .cdb_rob_o(cdb_rob_o),
    .cdb_busy_o(cdb_busy_o)
  );
  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", nm, obs, exp);
    end
  endtask
  task automatic step(output logic [3:0] a);
    int hit, idx;
    logic [3:0] seen;
    a = (rst && !flush) ? vld & rdy : 4'b0;
    for (int k = 0; k < 4; k++)
      if (a[k]) begin
        e_val.push_back({tg[k], rb[k]});
        e_fu.push_back(k);
      end
    @(posedge clk);
    #1;
    if (!rst || flush) begin
      e_val.delete();
      e_fu.delete();
    end
    if (cdb_vld_o) begin
      hit = -1;
      idx = -1;
      seen = '0;
      for (int i = 0; i < e_val.size(); i++)
        if (!seen[e_fu[i]]) begin
          seen[e_fu[i]] = 1'b1;
          if (hit < 0 && e_val[i] == {cdb_tag_o, cdb_rob_o}) begin
            hit = e_fu[i];
            idx = i;
          end
        end
      chk("sb_head_match", {cdb_tag_o, cdb_rob_o, 1'b0} | 32'(hit >= 0), {cdb_tag_o, cdb_rob_o, 1'b1});
      if (idx >= 0) begin
        e_val.delete(idx);
        e_fu.delete(idx);
        log_tag.push_back(cdb_tag_o);
        log_fu.push_back(hit);
      end
    end
  endtask
  task automatic do_reset();
    logic [3:0] a;
    vld = '0;
    rst = 1'b0;
    step(a);
    rst = 1'b1;
    log_tag.delete();
    log_fu.delete();
    for (int k = 0; k < 4; k++) n[k] = 0;
  endtask
  task automatic drain();
    logic [3:0] a;
    vld = '0;
    for (int i = 0; i < 24 && (cdb_busy_o || cdb_vld_o); i++) step(a);
    chk("drain_idle", {cdb_busy_o, cdb_vld_o}, 2'b00);
    chk("sb_empty", e_val.size(), 0);
  endtask
  task automatic feed(input logic [3:0] a);
    for (int k = 0; k < 4; k++) begin
      if (a[k]) n[k]++;
      tg[k] = {2'(k), 4'(n[k])};
      rb[k] = 5'(n[k]);
    end
  endtask
  initial begin
    int cntf [4];
    int last [4];
    int gap;
    logic [5:0] exp3 [8];
    exp3 = '{6'h20, 6'h10, 6'h21, 6'h11, 6'h22, 6'h12, 6'h23, 6'h13};
    for (int k = 0; k < 4; k++) begin
      tg[k] = '0;
      rb[k] = '0;
    end
    step(acc);
    step(acc);
    chk("rst_vld", cdb_vld_o, 0);
    chk("rst_tag", cdb_tag_o, 0);
    chk("rst_rob", cdb_rob_o, 0);
    chk("rst_busy", cdb_busy_o, 0);
    chk("rst_rdy", rdy, 4'hf);
    rst = 1'b1;
    step(acc);
    tg[2] = 6'h15;
    rb[2] = 5'h07;
    vld = 4'b0100;
    step(acc);
    vld = '0;
    chk("single_acc", acc, 4'b0100);
    chk("single_t1_vld", cdb_vld_o, 0);
    chk("single_busy", cdb_busy_o, 1);
    step(acc);
    chk("single_t2_vld", cdb_vld_o, 1);
    chk("single_tag", cdb_tag_o, 6'h15);
    chk("single_rob", cdb_rob_o, 5'h07);
    step(acc);
    chk("single_t3_vld", cdb_vld_o, 0);
    chk("single_t3_tag", cdb_tag_o, 0);
    do_reset();
    for (int k = 0; k < 4; k++) begin
      tg[k] = 6'(k + 1);
      rb[k] = 5'(k + 17);
    end
    vld = 4'hf;
    step(acc);
    vld = '0;
    chk("burst_acc", acc, 4'hf);
    for (int i = 0; i < 4; i++) step(acc);
    chk("burst_cnt", log_tag.size(), 4);
    for (int i = 0; i < 4 && i < log_tag.size(); i++) chk("burst_order", log_tag[i], i + 1);
    drain();
    do_reset();
    vld = 4'b0011;
    for (int i = 0; i < 9; i++) begin
      tg[0] = 6'h20 + 6'(n[0]);
      rb[0] = tg[0][4:0];
      tg[1] = 6'h10 + 6'(n[1]);
      rb[1] = tg[1][4:0];
      step(acc);
      if (acc[0]) n[0]++;
      if (acc[1]) n[1]++;
      if (n[1] == 4) vld[1] = 1'b0;
      if (i == 1) chk("bp_rdy1_low", rdy[1], 0);
    end
    chk("bp_fu1_accepts", n[1], 4);
    chk("bp_cnt", log_tag.size(), 8);
    for (int i = 0; i < 8 && i < log_tag.size(); i++) chk("bp_order", log_tag[i], exp3[i]);
    drain();
    do_reset();
    feed(4'b0);
    vld = 4'hf;
    for (int i = 0; i < 41; i++) begin
      step(acc);
      feed(acc);
    end
    vld = '0;
    chk("fair_cnt", log_fu.size() >= 40, 1);
    for (int k = 0; k < 4; k++) begin
      cntf[k] = 0;
      last[k] = -1;
    end
    gap = 0;
    for (int i = 0; i < 40 && i < log_fu.size(); i++) begin
      cntf[log_fu[i]]++;
      if (last[log_fu[i]] >= 0 && i - last[log_fu[i]] > gap) gap = i - last[log_fu[i]];
      last[log_fu[i]] = i;
    end
    for (int k = 0; k < 4; k++) chk("fair_per_fu", cntf[k], 10);
    chk("fair_max_gap", gap, 4);
    drain();
    do_reset();
    tg[0] = 6'h31;
    tg[1] = 6'h32;
    tg[3] = 6'h34;
    vld = 4'b1011;
    step(acc);
    vld = '0;
    chk("mid_busy", cdb_busy_o, 1);
    rst = 1'b0;
    step(acc);
    chk("mid_rst_vld", cdb_vld_o, 0);
    chk("mid_rst_busy", cdb_busy_o, 0);
    chk("mid_rst_rdy", rdy, 4'hf);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(acc);
      chk("mid_no_stale", cdb_vld_o, 0);
    end
`ifdef CDB_FLUSH_EN
    do_reset();
    feed(4'b0);
    vld = 4'hf;
    for (int i = 0; i < 4; i++) begin
      step(acc);
      feed(acc);
    end
    chk("fl_full", rdy != 4'hf, 1);
    flush = 1'b1;
    vld = 4'b1000;
    tg[3] = 6'h2a;
    rb[3] = 5'h0a;
    step(acc);
    flush = 1'b0;
    vld = '0;
    chk("fl_vld", cdb_vld_o, 0);
    chk("fl_busy", cdb_busy_o, 0);
    chk("fl_rdy", rdy, 4'hf);
    for (int i = 0; i < 4; i++) begin
      step(acc);
      chk("fl_no_bcast", cdb_vld_o, 0);
    end
    for (int i = 0; i < log_tag.size(); i++) chk("fl_no_2a", log_tag[i] == 6'h2a, 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
